mmio_board_io: RTL
==================

// Module: mmio_board_io
// PURPOSE
//  Parametrised memory-mapped board I/O controller on the CPU data bus.
//  Debounces two push-buttons and latches switches on a right-press.
//  Stages LED values written by the CPU and commits them on a left-press.
//  Adds sticky status, write-1-to-clear flags, press counters and a maskable interrupt.
// PARAMETERS
//  SW_W      16  switch input width (1..32)
//  LED_W     12  LED output width (1..32)
//  DEB_CYC   4   consecutive stable synchronised samples required to accept a button level (>=1)
//  CNT_W     16  width of each press counter (1..16)
// PORTS
//  clk       in   1      clock
//  reset     in   1      synchronous, active-high reset
//  rd_en     in   1      bus read strobe
//  wr_en     in   1      bus write strobe
//  addr      in   3      word address
//  wdata     in   32     bus write data
//  rdata     out  32     registered read data
//  rvalid    out  1      pulses 1 cycle after rd_en
//  btn_l     in   1      raw left button, asynchronous
//  btn_r     in   1      raw right button, asynchronous
//  sw_in     in   SW_W   raw switches, asynchronous
//  led_out   out  LED_W  committed LED value
//  irq       out  1      registered level interrupt
// BEHAVIOUR
//  Reset: rdata=0, rvalid=0, led_out=0, irq=0; all internal registers 0.
//   Internal registers: staging, sw_latch, STATUS, IRQ_EN, counters, synchronisers, debouncers.
//  Input path: btn_l, btn_r and sw_in each pass through a 2-flop synchroniser.
//   Per-button debouncer: a counter counts cycles where the synchronised level differs from the debounced level.
//   The counter resets to 0 whenever the two levels match.
//   At DEB_CYC the debounced level flips.
//   A 0->1 flip of the debounced level gives one press pulse (1 cycle).
//   Worst case from a raw edge to its press pulse: 2 + DEB_CYC cycles.
//  Right press: sw_latch <= synchronised sw_in; STATUS.SW_RDY <= 1; RCNT++.
//  Left press: led_out <= staging; STATUS.LED_DONE <= 1; LCNT++.
//  Counters wrap from all-ones to 0.
//  Register map (addr):
//   0 STATUS  R: {30'b0, LED_DONE, SW_RDY}; W: write-1-to-clear on bits [1:0].
//   1 LED     R/W: staging[LED_W-1:0]; a write also clears LED_DONE.
//   2 SWITCH  R: zero-extended sw_latch; the read also clears SW_RDY.
//   3 IRQ_EN  R/W: bits [1:0] enable SW_RDY / LED_DONE.
//   4 COUNT   R: {zero-ext LCNT in [31:16], zero-ext RCNT in [15:0]}; any write clears both counters.
//   5-7       read 0, writes ignored.
//  Read timing:
//   rdata is updated in the cycle after rd_en and rvalid=1 in that cycle.
//   rdata holds its value when rd_en=0.
//   Read side-effects take place on the rd_en cycle.
//  Simultaneous events:
//   rd_en and wr_en in the same cycle: both act; rdata returns the pre-write value.
//   Set and clear of a flag in the same cycle: set wins.
//   Exception: an LED write coinciding with a left press leaves LED_DONE=0.
//    led_out takes the old staging value; staging takes wdata.
//   A press coinciding with a COUNT write: the counter ends at 1.
//  irq: registered |(STATUS & IRQ_EN); updates one cycle after the flag change.
//  Reset mid-operation: debounce progress, pending flags and counters are all discarded.
//   Press pulses are suppressed for DEB_CYC cycles after reset is released.
// TESTING
//  1. Reset: btn held high during reset -> after release all outputs 0; first press pulse no earlier than 2+DEB_CYC cycles.
//  2. Bounce: btn_r toggles every 2 cycles for 20 cycles, then stays high (DEB_CYC=4) -> exactly one RCNT increment.
//     Same scenario -> SW_RDY=1 and read addr2 returns sw_in=16'hA5C3, after which SW_RDY=0.
//  3. LED: write addr1=32'h0000_0FAB, then left press -> led_out=12'hFAB, LED_DONE=1.
//     With IRQ_EN=2'b10 -> irq=1; write addr0=2 -> LED_DONE=0 and irq=0 the next cycle.
//  4. Collision: LED write 12'h123 on the same cycle as a left press, staging previously 12'h0F0.
//     -> led_out=12'h0F0, staging=12'h123, LED_DONE=0.
//  5. Read/write same cycle on addr3: old value 0, wdata 3 -> rdata=0 and rvalid=1 next cycle; a following read returns 3.
//  6. Wrap: CNT_W=2, 5 right presses -> COUNT[15:0]=1; write addr4 -> COUNT=0.

Source files
------------

// File: rtl/mmio_board_io.sv
// Memory-mapped board I/O: debounced buttons, switch latch, staged LED commit,
// sticky W1C status, press counters and a maskable level interrupt.
module mmio_board_io #(
    parameter int SW_W    = 16,
    parameter int LED_W   = 12,
    parameter int DEB_CYC = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_en,
    input  logic             wr_en,
    input  logic [2:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             rvalid,
    input  logic             btn_l,
    input  logic             btn_r,
    input  logic [SW_W-1:0]  sw_in,
    output logic [LED_W-1:0] led_out,
    output logic             irq
);
    localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    // index 0 = left button, 1 = right button
    logic [1:0]      r_btn_s1, r_btn_s2;
    logic [SW_W-1:0] r_sw_s1, r_sw_s2;
    logic [1:0]      w_press;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
        end else begin
            r_btn_s1 <= {btn_r, btn_l};
            r_btn_s2 <= r_btn_s1;
            r_sw_s1  <= sw_in;
            r_sw_s2  <= r_sw_s1;
        end
    end

    generate
        for (genvar g = 0; g < 2; g++) begin : g_deb
            logic          r_deb;
            logic [DW-1:0] r_dcnt;
            logic          w_flip;

            // The flip happens on the DEB_CYC-th consecutive differing sample.
            assign w_flip     = (r_btn_s2[g] != r_deb) && (r_dcnt == DW'(DEB_CYC - 1));
            assign w_press[g] = w_flip & r_btn_s2[g];

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_deb  <= 1'b0;
                    r_dcnt <= '0;
                end else if (r_btn_s2[g] == r_deb) begin
                    r_dcnt <= '0;
                end else if (w_flip) begin
                    r_deb  <= r_btn_s2[g];
                    r_dcnt <= '0;
                end else begin
                    r_dcnt <= r_dcnt + DW'(1);
                end
            end
        end
    endgenerate

    logic [LED_W-1:0] r_staging;
    logic [SW_W-1:0]  r_sw_latch;
    logic             r_sw_rdy, r_led_done;
    logic [1:0]       r_irq_en;
    logic [CNT_W-1:0] r_lcnt, r_rcnt;
    logic [31:0]      w_rd_mux;
    logic             w_wr_stat, w_wr_led, w_wr_en, w_wr_cnt, w_rd_sw;
    logic             w_unused;

    assign w_wr_stat = wr_en && (addr == 3'd0);
    assign w_wr_led  = wr_en && (addr == 3'd1);
    assign w_wr_en   = wr_en && (addr == 3'd3);
    assign w_wr_cnt  = wr_en && (addr == 3'd4);
    assign w_rd_sw   = rd_en && (addr == 3'd2);
    assign w_unused  = &{1'b0, wdata};

    always_comb begin
        w_rd_mux = '0;
        case (addr)
            3'd0:    w_rd_mux = {30'b0, r_led_done, r_sw_rdy};
            3'd1:    w_rd_mux = 32'(r_staging);
            3'd2:    w_rd_mux = 32'(r_sw_latch);
            3'd3:    w_rd_mux = {30'b0, r_irq_en};
            3'd4:    w_rd_mux = {16'(r_lcnt), 16'(r_rcnt)};
            default: w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_staging  <= '0;
            r_sw_latch <= '0;
            r_sw_rdy   <= 1'b0;
            r_led_done <= 1'b0;
            r_irq_en   <= '0;
            r_lcnt     <= '0;
            r_rcnt     <= '0;
            led_out    <= '0;
            rdata      <= '0;
            rvalid     <= 1'b0;
            irq        <= 1'b0;
        end else begin
            rvalid <= rd_en;
            if (rd_en)
                rdata <= w_rd_mux;
            irq <= |({r_led_done, r_sw_rdy} & r_irq_en);

            if (w_wr_led)
                r_staging <= wdata[LED_W-1:0];
            if (w_wr_en)
                r_irq_en <= wdata[1:0];

            if (w_press[1]) begin
                r_sw_latch <= r_sw_s2;
                r_sw_rdy   <= 1'b1;
            end else if ((w_wr_stat && wdata[0]) || w_rd_sw) begin
                r_sw_rdy <= 1'b0;
            end

            // An LED write beats a coincident commit: the new staging is not yet shown.
            if (w_press[0])
                led_out <= r_staging;
            if (w_wr_led)
                r_led_done <= 1'b0;
            else if (w_press[0])
                r_led_done <= 1'b1;
            else if (w_wr_stat && wdata[1])
                r_led_done <= 1'b0;

            if (w_press[0])
                r_lcnt <= w_wr_cnt ? CNT_W'(1) : r_lcnt + CNT_W'(1);
            else if (w_wr_cnt)
                r_lcnt <= '0;
            if (w_press[1])
                r_rcnt <= w_wr_cnt ? CNT_W'(1) : r_rcnt + CNT_W'(1);
            else if (w_wr_cnt)
                r_rcnt <= '0;
        end
    end
endmodule
